// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encodings
// and the arithmetic helpers used by the event counter.
package edge_det_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Helpers work on the widest supported channel/counter size; callers
    // zero-extend into these widths and keep only the bits they need.
    localparam int MAX_W = 32;

    function automatic logic [5:0] popcount(input logic [MAX_W-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [MAX_W:0] sat_add(input logic [MAX_W:0] a,
                                               input logic [MAX_W:0] b,
                                               input logic [MAX_W:0] max_val);
        logic [MAX_W:0] s;
        s = a + b;
        return (s > max_val) ? max_val : s;
    endfunction

endpackage

// File: rtl/edge_det_ch.sv
// One edge-detector channel: optional synchroniser, previous-level register,
// mode-qualified detection, registered pulses and a write-1-to-clear sticky flag.
module edge_det_ch
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       d,
    input  logic [1:0] mode,
    input  logic       clr,
    input  logic       det_en,
    output logic       p_edge,
    output logic       n_edge,
    output logic       evt,
    output logic       sticky,
    output logic       sticky_next,
    output logic       sel
);

    logic s;
    logic prev_reg;
    logic rise;
    logic fall;
    logic p_edge_reg;
    logic n_edge_reg;
    logic evt_reg;
    logic sticky_reg;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg[0] <= d;
                    for (int j = 1; j < SYNC_STAGES; j++) begin
                        sync_reg[j] <= sync_reg[j-1];
                    end
                end
            end

            assign s = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    // det_en is low during warm-up so levels present at reset release are not edges.
    always_comb begin
        rise        = det_en & s & ~prev_reg;
        fall        = det_en & ~s & prev_reg;
        sel         = ((mode == MODE_RISE || mode == MODE_BOTH) & rise)
                    | ((mode == MODE_FALL || mode == MODE_BOTH) & fall);
        sticky_next = (sticky_reg & ~clr) | sel;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_reg   <= 1'b0;
            p_edge_reg <= 1'b0;
            n_edge_reg <= 1'b0;
            evt_reg    <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            prev_reg   <= s;
            p_edge_reg <= rise;
            n_edge_reg <= fall;
            evt_reg    <= sel;
            sticky_reg <= sticky_next;
        end
    end

    assign p_edge = p_edge_reg;
    assign n_edge = n_edge_reg;
    assign evt    = evt_reg;
    assign sticky = sticky_reg;

endmodule

// File: rtl/edge_det_multi.sv
// Multi-channel edge detector top: per-channel detectors plus shared warm-up
// gating, saturating event counter and interrupt generation.
module edge_det_multi
    import edge_det_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WIDTH-1:0]   d,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]   clr,
    input  logic [WIDTH-1:0]   irq_en,
    input  logic               cnt_clr,
    output logic [WIDTH-1:0]   p_edge,
    output logic [WIDTH-1:0]   n_edge,
    output logic [WIDTH-1:0]   evt,
    output logic [WIDTH-1:0]   sticky,
    output logic [CNT_W-1:0]   evt_cnt,
    output logic               irq
);

    localparam int             WARM_MAX = SYNC_STAGES + 1;
    localparam logic [MAX_W:0] CNT_ONE  = 1;
    localparam logic [MAX_W:0] CNT_MAX  = (CNT_ONE << CNT_W) - CNT_ONE;

    logic [2:0]       warm_reg;
    logic             warm_done;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] sticky_next;
    logic [MAX_W-1:0] sel_wide;
    logic [5:0]       inc;
    logic [MAX_W:0]   inc_wide;
    logic [MAX_W:0]   cnt_wide;
    logic [MAX_W:0]   sum_wide;
    logic [CNT_W-1:0] evt_cnt_reg;
    logic [CNT_W-1:0] evt_cnt_next;
    logic             irq_reg;
    logic             irq_next;
    logic             unused_sum_bits;

    assign warm_done = (warm_reg == WARM_MAX[2:0]);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            warm_reg <= '0;
        end else if (!warm_done) begin
            warm_reg <= warm_reg + 3'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            edge_det_ch #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_ch (
                .clk        (clk),
                .rstn       (rstn),
                .d          (d[gi]),
                .mode       (mode[2*gi +: 2]),
                .clr        (clr[gi]),
                .det_en     (warm_done),
                .p_edge     (p_edge[gi]),
                .n_edge     (n_edge[gi]),
                .evt        (evt[gi]),
                .sticky     (sticky[gi]),
                .sticky_next(sticky_next[gi]),
                .sel        (sel[gi])
            );
        end
    endgenerate

    // A counter clear still counts this cycle's edges: base becomes zero, inc is kept.
    always_comb begin
        sel_wide               = '0;
        sel_wide[WIDTH-1:0]    = sel;
        inc                    = popcount(sel_wide);
        inc_wide               = '0;
        inc_wide[5:0]          = inc;
        cnt_wide               = '0;
        if (!cnt_clr) begin
            cnt_wide[CNT_W-1:0] = evt_cnt_reg;
        end
        sum_wide               = sat_add(cnt_wide, inc_wide, CNT_MAX);
        evt_cnt_next           = sum_wide[CNT_W-1:0];
        irq_next               = |(sticky_next & irq_en);
    end

    assign unused_sum_bits = ^sum_wide[MAX_W:CNT_W];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            evt_cnt_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            evt_cnt_reg <= evt_cnt_next;
            irq_reg     <= irq_next;
        end
    end

    assign evt_cnt = evt_cnt_reg;
    assign irq     = irq_reg;

endmodule

// File: tb/tb_edge_det_multi.sv
// Self-checking bench for edge_det_multi: table vectors, directed corner
// sequences and randomized traffic against a sample-history reference model.
module tb_edge_det_multi;

    localparam int W = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [W-1:0]   d = '0;
    logic [2*W-1:0] mode = '0;
    logic [W-1:0]   clr = '0;
    logic [W-1:0]   irq_en = '0;
    logic           cnt_clr = 1'b0;

    logic [W-1:0]   p_edge, n_edge, evt, sticky;
    logic [7:0]     evt_cnt;
    logic           irq;

    logic [W-1:0]   unused_sp, unused_sn, unused_se, unused_ss;
    logic [2:0]     sat_cnt;
    logic           unused_sirq;

    int n_tests = 0;
    int n_fail  = 0;

    edge_det_multi #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(8)) u_dut (
        .clk(clk), .rstn(rstn), .d(d), .mode(mode), .clr(clr), .irq_en(irq_en),
        .cnt_clr(cnt_clr), .p_edge(p_edge), .n_edge(n_edge), .evt(evt),
        .sticky(sticky), .evt_cnt(evt_cnt), .irq(irq)
    );

    edge_det_multi #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(3)) u_sat (
        .clk(clk), .rstn(rstn), .d(d), .mode(mode), .clr(clr), .irq_en(irq_en),
        .cnt_clr(cnt_clr), .p_edge(unused_sp), .n_edge(unused_sn), .evt(unused_se),
        .sticky(unused_ss), .evt_cnt(sat_cnt), .irq(unused_sirq)
    );

    always #5 clk = ~clk;

    // Reference model: d samples taken since reset release; an edge is reported
    // S edges after it is sampled, and only once both compared samples exist.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_p, m_n, m_evt, m_sticky;
    logic         m_irq;
    int           m_cnt8, m_cnt3;

    task automatic model_update();
        logic [W-1:0] nw, od, rise, fall;
        int n, inc;
        if (!rstn) begin
            hist.delete();
            m_p = '0; m_n = '0; m_evt = '0; m_sticky = '0; m_irq = 1'b0;
            m_cnt8 = 0; m_cnt3 = 0;
        end else begin
            hist.push_back(d);
            n = hist.size();
            rise = '0;
            fall = '0;
            if (n >= S + 2) begin
                nw   = hist[n-S-1];
                od   = hist[n-S-2];
                rise = nw & ~od;
                fall = ~nw & od;
            end
            m_p = rise;
            m_n = fall;
            for (int i = 0; i < W; i++) begin
                m_evt[i] = (mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]);
            end
            m_sticky = (m_sticky & ~clr) | m_evt;
            m_irq    = |(m_sticky & irq_en);
            inc      = $countones(m_evt);
            m_cnt8   = cnt_clr ? inc : ((m_cnt8 + inc > 255) ? 255 : m_cnt8 + inc);
            m_cnt3   = cnt_clr ? inc : ((m_cnt3 + inc > 7) ? 7 : m_cnt3 + inc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " p_edge"},  32'(p_edge),  32'(m_p));
        chk({tag, " n_edge"},  32'(n_edge),  32'(m_n));
        chk({tag, " evt"},     32'(evt),     32'(m_evt));
        chk({tag, " sticky"},  32'(sticky),  32'(m_sticky));
        chk({tag, " irq"},     32'(irq),     32'(m_irq));
        chk({tag, " evt_cnt"}, 32'(evt_cnt), 32'(m_cnt8));
        chk({tag, " sat_cnt"}, 32'(sat_cnt), 32'(m_cnt3));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        chk("reset p_edge",  32'(p_edge),  32'd0);
        chk("reset n_edge",  32'(n_edge),  32'd0);
        chk("reset evt",     32'(evt),     32'd0);
        chk("reset sticky",  32'(sticky),  32'd0);
        chk("reset evt_cnt", 32'(evt_cnt), 32'd0);
        chk("reset irq",     32'(irq),     32'd0);
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] clr;
        logic [W-1:0] p;
        logic [W-1:0] n;
        logic [W-1:0] e;
        logic [W-1:0] st;
        int           cnt;
        logic         irq;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Mode table: ch0 off, ch1 rise, ch2 fall, ch3 both; irq only from ch3.
        tbl[0] = '{d: 4'hf, clr: 4'h0, p: 4'h0, n: 4'h0, e: 4'h0, st: 4'h0, cnt: 0, irq: 1'b0};
        tbl[1] = '{d: 4'hf, clr: 4'h0, p: 4'h0, n: 4'h0, e: 4'h0, st: 4'h0, cnt: 0, irq: 1'b0};
        tbl[2] = '{d: 4'hf, clr: 4'h0, p: 4'hf, n: 4'h0, e: 4'ha, st: 4'ha, cnt: 2, irq: 1'b1};
        tbl[3] = '{d: 4'h0, clr: 4'h0, p: 4'h0, n: 4'h0, e: 4'h0, st: 4'ha, cnt: 2, irq: 1'b1};
        tbl[4] = '{d: 4'h0, clr: 4'h0, p: 4'h0, n: 4'h0, e: 4'h0, st: 4'ha, cnt: 2, irq: 1'b1};
        tbl[5] = '{d: 4'h0, clr: 4'h0, p: 4'h0, n: 4'hf, e: 4'hc, st: 4'he, cnt: 4, irq: 1'b1};
        tbl[6] = '{d: 4'h0, clr: 4'h8, p: 4'h0, n: 4'h0, e: 4'h0, st: 4'h6, cnt: 4, irq: 1'b0};
        tbl[7] = '{d: 4'h0, clr: 4'h0, p: 4'h0, n: 4'h0, e: 4'h0, st: 4'h6, cnt: 4, irq: 1'b0};

        // Latency: pulse appears exactly S edges after the first sampling edge.
        mode = 8'b01010101;
        do_reset();
        repeat (5) tick();
        d = 4'b0001;
        tick();
        chk("lat k p_edge", 32'(p_edge), 32'd0);
        tick();
        chk("lat k+1 p_edge", 32'(p_edge), 32'd0);
        tick();
        chk("lat k+2 p_edge",  32'(p_edge),  32'h1);
        chk("lat k+2 evt",     32'(evt),     32'h1);
        chk("lat k+2 sticky",  32'(sticky),  32'h1);
        chk("lat k+2 evt_cnt", 32'(evt_cnt), 32'd1);
        tick();
        chk("lat k+3 p_edge",  32'(p_edge),  32'd0);
        chk("lat k+3 evt",     32'(evt),     32'd0);
        repeat (3) tick();
        chk("lat hold sticky",  32'(sticky),  32'h1);
        chk("lat hold evt_cnt", 32'(evt_cnt), 32'd1);
        chk("lat hold sat_cnt", 32'(sat_cnt), 32'd1);

        // Warm-up: level already high at reset release is not an edge.
        d    = 4'hf;
        mode = 8'hff;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("warm %0d p_edge", i), 32'(p_edge), 32'd0);
            chk($sformatf("warm %0d evt", i),    32'(evt),    32'd0);
        end
        chk("warm evt_cnt", 32'(evt_cnt), 32'd0);

        // Table-driven mode/sticky/irq vectors.
        d      = 4'h0;
        mode   = 8'b11100100;
        irq_en = 4'h8;
        do_reset();
        repeat (5) tick();
        for (int i = 0; i < 8; i++) begin
            d   = tbl[i].d;
            clr = tbl[i].clr;
            tick();
            chk($sformatf("tbl %0d p_edge", i),  32'(p_edge),  32'(tbl[i].p));
            chk($sformatf("tbl %0d n_edge", i),  32'(n_edge),  32'(tbl[i].n));
            chk($sformatf("tbl %0d evt", i),     32'(evt),     32'(tbl[i].e));
            chk($sformatf("tbl %0d sticky", i),  32'(sticky),  32'(tbl[i].st));
            chk($sformatf("tbl %0d evt_cnt", i), 32'(evt_cnt), 32'(tbl[i].cnt));
            chk($sformatf("tbl %0d irq", i),     32'(irq),     32'(tbl[i].irq));
        end
        clr = '0;

        // Sticky set wins over a simultaneous clear.
        mode   = 8'hff;
        irq_en = 4'h2;
        d      = 4'h0;
        do_reset();
        repeat (5) tick();
        d = 4'h2;
        repeat (3) tick();
        chk("stk first evt",    32'(evt),    32'h2);
        chk("stk first sticky", 32'(sticky), 32'h2);
        chk("stk first irq",    32'(irq),    32'd1);
        d = 4'h0;
        repeat (2) tick();
        clr = 4'h2;
        tick();
        chk("stk clr+evt n_edge", 32'(n_edge), 32'h2);
        chk("stk clr+evt sticky", 32'(sticky), 32'h2);
        chk("stk clr+evt irq",    32'(irq),    32'd1);
        clr = 4'h0;
        tick();
        chk("stk after sticky", 32'(sticky), 32'h2);
        chk("stk after irq",    32'(irq),    32'd1);
        clr = 4'h2;
        tick();
        chk("stk cleared sticky", 32'(sticky), 32'h0);
        chk("stk cleared irq",    32'(irq),    32'd0);
        clr = 4'h0;

        // Counter saturation on the narrow counter, then clear with 4 edges.
        mode = 8'hff;
        d    = 4'h0;
        do_reset();
        repeat (5) tick();
        for (int i = 0; i < 4; i++) begin
            d = ~d;
            repeat (4) tick();
            chk($sformatf("sat toggle %0d", i), 32'(sat_cnt), (i == 0) ? 32'd4 : 32'd7);
        end
        chk("sat wide evt_cnt", 32'(evt_cnt), 32'd16);
        d = ~d;
        repeat (2) tick();
        cnt_clr = 1'b1;
        tick();
        chk("cnt_clr sat_cnt", 32'(sat_cnt), 32'd4);
        chk("cnt_clr evt_cnt", 32'(evt_cnt), 32'd4);
        cnt_clr = 1'b0;
        tick();
        chk("cnt_clr after", 32'(sat_cnt), 32'd4);

        // Reset on the edge where p_edge would assert.
        mode   = 8'hff;
        irq_en = 4'hf;
        d      = 4'h0;
        do_reset();
        repeat (5) tick();
        d = 4'hf;
        repeat (3) tick();
        d = 4'h0;
        repeat (3) tick();
        chk("rmid pre sticky", 32'(sticky), 32'hf);
        chk("rmid pre irq",    32'(irq),    32'd1);
        d = 4'hf;
        repeat (2) tick();
        rstn = 1'b0;
        tick();
        chk("rmid p_edge",  32'(p_edge),  32'd0);
        chk("rmid sticky",  32'(sticky),  32'd0);
        chk("rmid evt_cnt", 32'(evt_cnt), 32'd0);
        chk("rmid irq",     32'(irq),     32'd0);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rmid warm %0d p_edge", i), 32'(p_edge), 32'd0);
        end

        // Randomized traffic against the reference model.
        clr = '0;
        cnt_clr = 1'b0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            d = W'($urandom);
            if (i % 50 == 0) mode = (2*W)'($urandom);
            if (i % 20 == 0) irq_en = W'($urandom);
            clr     = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            cnt_clr = ($urandom_range(0, 15) == 0);
            rstn    = ($urandom_range(0, 199) != 0);
            tick();
            chk_model($sformatf("rand %0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
